// File: rtl/simple_out_port_if.sv
// Core/host handshake bundle for simple_out_port: OUT-instruction strobe bus on one side,
// show-ahead valid/ready drain on the other.
interface simple_out_port_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] out_data;
    logic             out_strobe;
    logic             cpu_stall;
    logic [WIDTH-1:0] host_data;
    logic             host_valid;
    logic             host_ready;

    modport master (
        output out_data, out_strobe, host_ready,
        input  cpu_stall, host_data, host_valid
    );

    modport slave (
        input  out_data, out_strobe, host_ready,
        output cpu_stall, host_data, host_valid
    );
endinterface

// File: rtl/simple_out_port.sv
// OUT-instruction receiver: buffers core words in a show-ahead FIFO and drains them to a host.
// Define SIMPLE_OUT_LAST_EN to build the last_data register that holds the latest accepted word.
module simple_out_port #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    simple_out_port_if.slave       bus,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [WIDTH-1:0]       last_data
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q;
    logic             full, pop, push, drop;

    always_comb begin
        full = (count_q == FULL_COUNT);
        pop  = (count_q != '0) && bus.host_ready;
        // A pop in the same cycle frees a slot, so a strobe while full is still accepted.
        push = bus.out_strobe && (!full || pop);
        drop = bus.out_strobe && full && !pop;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wp_q] <= bus.out_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wp_q <= wp_q + AW'(1);
            end
            if (pop) begin
                rp_q <= rp_q + AW'(1);
            end
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.cpu_stall  = full;
    assign bus.host_valid = (count_q != '0);
    // Gated so the head reads zero out of reset even though the storage array is not reset.
    assign bus.host_data  = bus.host_valid ? mem[rp_q] : '0;
    assign count          = count_q;
    assign overflow       = overflow_q;

`ifdef SIMPLE_OUT_LAST_EN
    logic [WIDTH-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (push && !clear) begin
            last_q <= bus.out_data;
        end
    end

    assign last_data = last_q;
`else
    assign last_data = '0;
`endif
endmodule

// File: tb/tb_simple_out_port.sv
// Directed, table-driven bench for simple_out_port with hand-written reset sequences.
module tb_simple_out_port;
`ifdef SIMPLE_OUT_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    typedef struct {
        logic        strobe;
        logic [15:0] data;
        logic        ready;
        logic        clr;
        logic [3:0]  count;
        logic        valid;
        logic [15:0] head;
        logic        stall;
        logic        ovf;
        logic [15:0] last;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] last_data;

    int passed = 0;
    int total  = 0;
    vec_t vecs[$];
    logic [15:0] last_model = 16'h0000;

    simple_out_port_if #(.WIDTH(16)) bus ();

    simple_out_port #(.DEPTH(8), .WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clear     (clear),
        .count     (count),
        .overflow  (overflow),
        .last_data (last_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // acc marks a strobe the FIFO should accept, which is what moves last_data.
    function automatic void add(input logic s, input logic [15:0] d, input logic r,
                                input logic c, input logic [3:0] n, input logic [15:0] h,
                                input logic o, input logic acc);
        vec_t v;
        if (acc) last_model = d;
        v.strobe = s; v.data = d; v.ready = r; v.clr = c;
        v.count = n; v.valid = (n != 0); v.head = h; v.stall = (n == 4'd8); v.ovf = o;
        v.last = LAST_EN ? last_model : 16'h0000;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic s, input logic [15:0] d, input logic r, input logic c);
        bus.out_strobe = s;
        bus.out_data   = d;
        bus.host_ready = r;
        clear          = c;
    endtask

    initial begin
        // Single word, then pop
        add(1'b1, 16'h1234, 1'b0, 1'b0, 4'd1, 16'h1234, 1'b0, 1'b1);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        // Fill, drop a ninth, drain in order
        for (int i = 1; i <= 8; i++)
            add(1'b1, 16'(i), 1'b0, 1'b0, 4'(i), 16'h0001, 1'b0, 1'b1);
        add(1'b1, 16'h0009, 1'b0, 1'b0, 4'd8, 16'h0001, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++)
            add(1'b0, 16'h0000, 1'b1, 1'b0, 4'(8 - k), 16'(k + 1), 1'b1, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b0);
        // Full with simultaneous push and pop
        for (int i = 1; i <= 8; i++)
            add(1'b1, 16'(i), 1'b0, 1'b0, 4'(i), 16'h0001, 1'b0, 1'b1);
        add(1'b1, 16'hAAAA, 1'b1, 1'b0, 4'd8, 16'h0002, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++)
            add(1'b0, 16'h0000, 1'b1, 1'b0, 4'(8 - k), (k == 7) ? 16'hAAAA : 16'(k + 2),
                1'b0, 1'b0);
        // Wrap-around streaming
        for (int i = 0; i < 20; i++)
            add(1'b1, 16'(16'h0100 + i), 1'b1, 1'b0, 4'd1, 16'(16'h0100 + i), 1'b0, 1'b1);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        // Clear priority: reach count=3 with overflow set, then clear alongside a strobe
        for (int i = 1; i <= 8; i++)
            add(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0, 4'(i), 16'h0011, 1'b0, 1'b1);
        add(1'b1, 16'h0099, 1'b0, 1'b0, 4'd8, 16'h0011, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++)
            add(1'b0, 16'h0000, 1'b1, 1'b0, 4'(8 - k), 16'(16'h0011 + k), 1'b1, 1'b0);
        add(1'b1, 16'hBEEF, 1'b0, 1'b1, 4'd0, 16'h0000, 1'b0, 1'b0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 32'(count), 32'd0);
        chk("reset valid", 32'(bus.host_valid), 32'd0);
        chk("reset stall", 32'(bus.cpu_stall), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset host_data", 32'(bus.host_data), 32'd0);
        chk("reset last_data", 32'(last_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].strobe, vecs[i].data, vecs[i].ready, vecs[i].clr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].count));
            chk($sformatf("v%0d valid", i), 32'(bus.host_valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d stall", i), 32'(bus.cpu_stall), 32'(vecs[i].stall));
            chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d last_data", i), 32'(last_data), 32'(vecs[i].last));
            if (vecs[i].valid)
                chk($sformatf("v%0d head", i), 32'(bus.host_data), 32'(vecs[i].head));
        end

        // Async reset mid-stream
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("pre-reset count", 32'(count), 32'd5);
        chk("pre-reset head", 32'(bus.host_data), 32'h0201);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async count", 32'(count), 32'd0);
        chk("async valid", 32'(bus.host_valid), 32'd0);
        chk("async stall", 32'(bus.cpu_stall), 32'd0);
        chk("async overflow", 32'(overflow), 32'd0);
        chk("async host_data", 32'(bus.host_data), 32'd0);
        chk("async last_data", 32'(last_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h5A5A, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("post-reset count", 32'(count), 32'd1);
        chk("post-reset valid", 32'(bus.host_valid), 32'd1);
        chk("post-reset head", 32'(bus.host_data), 32'h5A5A);
        chk("post-reset last_data", 32'(last_data), LAST_EN ? 32'h5A5A : 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
